// File: rtl/fb_rect_writer.sv
// fb_rect_writer: fills a rectangle of a frame buffer with one RGB444 color,
// one pixel per clock, in raster order, through a block RAM write port.
//
// Build option: define FB_RECT_CLIP_EN to clip the rectangle against the
// FB_W x FB_H frame. Without it the rectangle is used as given and
// addresses wrap modulo 2^15.
//
// state | meaning
// IDLE  | waiting for start; rectangle parameters captured on start
// SETUP | derive effective width/height and the first row base address
// FILL  | one write per cycle, left-to-right then top-to-bottom
// DONE  | single-cycle completion pulse, then back to IDLE
module fb_rect_writer #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [6:0]  y0,
  input  logic [7:0]  w,
  input  logic [6:0]  h,
  input  logic [11:0] color,
  output logic        busy,
  output logic        done,
  output logic        wea,
  output logic [14:0] addra,
  output logic [11:0] dina
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [14:0] FB_W15 = 15'(FB_W);

  // The coordinate ports are 8/7 bits wide and the address is 15 bits.
  if (FB_W < 1 || FB_W > 255 || FB_H < 1 || FB_H > 127 || FB_W * FB_H > 32768) begin : g_bad_size
    $error("fb_rect_writer: frame size does not fit the port widths");
  end

  state_e      state_q, state_d;

  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [7:0]  w_q, w_d;
  logic [6:0]  h_q, h_d;
  logic [11:0] color_q, color_d;

  logic [7:0]  ew_q, ew_d;
  logic [7:0]  col_cnt_q, col_cnt_d;
  logic [6:0]  row_cnt_q, row_cnt_d;
  logic [14:0] row_base_q, row_base_d;
  logic [14:0] addr_q, addr_d;

  logic [7:0]  ew;
  logic [6:0]  eh;
  logic [14:0] setup_base;
  logic        last_pixel;

`ifdef FB_RECT_CLIP_EN
  localparam logic [8:0] FB_W9 = 9'(FB_W);
  localparam logic [7:0] FB_H8 = 8'(FB_H);

  logic [8:0] x_room;
  logic [7:0] y_room;

  // Effective size clipped to the frame: zero if the origin is off-frame.
  always_comb begin
    x_room = FB_W9 - {1'b0, x0_q};
    y_room = FB_H8 - {1'b0, y0_q};
    ew     = 8'd0;
    eh     = 7'd0;
    if ({1'b0, x0_q} < FB_W9) begin
      ew = ({1'b0, w_q} < x_room) ? w_q : x_room[7:0];
    end
    if ({1'b0, y0_q} < FB_H8) begin
      eh = ({1'b0, h_q} < y_room) ? h_q : y_room[6:0];
    end
  end
`else
  // Unclipped: the caller guarantees the rectangle is in range.
  assign ew = w_q;
  assign eh = h_q;
`endif

  // The only multiply; it is used once per rectangle, in SETUP.
  assign setup_base = {8'd0, y0_q} * FB_W15;
  assign last_pixel = (col_cnt_q == 8'd0) && (row_cnt_q == 7'd0);

  // State register, asynchronously forced to IDLE by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = SETUP;
      SETUP: state_d = ((ew != 8'd0) && (eh != 7'd0)) ? FILL : DONE;
      FILL:  if (last_pixel) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status and write-enable outputs decoded from the current state.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    wea  = (state_q == FILL);
  end

  // Datapath next values: capture, setup of counters, raster walk.
  always_comb begin
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    ew_d       = ew_q;
    col_cnt_d  = col_cnt_q;
    row_cnt_d  = row_cnt_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = w;
          h_d     = h;
          color_d = color;
        end
      end
      SETUP: begin
        // Counters run down to zero; their value for a zero-size
        // rectangle is never used because FILL is skipped.
        ew_d       = ew;
        col_cnt_d  = ew - 8'd1;
        row_cnt_d  = eh - 7'd1;
        row_base_d = setup_base;
        addr_d     = setup_base + {7'd0, x0_q};
      end
      FILL: begin
        if (col_cnt_q != 8'd0) begin
          col_cnt_d = col_cnt_q - 8'd1;
          addr_d    = addr_q + 15'd1;
        end else if (row_cnt_q != 7'd0) begin
          // Row advance by addition only.
          col_cnt_d  = ew_q - 8'd1;
          row_cnt_d  = row_cnt_q - 7'd1;
          row_base_d = row_base_q + FB_W15;
          addr_d     = row_base_q + FB_W15 + {7'd0, x0_q};
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      ew_q       <= '0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      ew_q       <= ew_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  assign addra = addr_q;
  assign dina  = color_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: scoreboard of expected (address, data) writes
// built from an independent raster model, plus latency and reset checks.
module tb_fb_rect_writer;

  localparam int FB_W = 160;
  localparam int FB_H = 120;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [7:0]  w;
  logic [6:0]  h;
  logic [11:0] color;
  logic        busy;
  logic        done;
  logic        wea;
  logic [14:0] addra;
  logic [11:0] dina;

  fb_rect_writer #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x0    (x0),
    .y0    (y0),
    .w     (w),
    .h     (h),
    .color (color),
    .busy  (busy),
    .done  (done),
    .wea   (wea),
    .addra (addra),
    .dina  (dina)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  logic [26:0] exp_q[$];
  int wr_cnt, first_wr, last_wr, done_cnt, done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: every write is popped against the scoreboard.
  initial begin
    wr_cnt = 0; first_wr = -1; last_wr = -1; done_cnt = 0; done_cyc = -1;
    forever begin
      @(negedge clk);
      if (wea === 1'b1) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {31'd0, wea}, 32'd0);
        end else begin
          logic [26:0] e;
          e = exp_q.pop_front();
          chk("addra", {17'd0, addra}, {17'd0, e[26:12]});
          chk("dina", {20'd0, dina}, {20'd0, e[11:0]});
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Drive one rectangle request and check writes, latency and done pulse.
  // Must be entered away from a rising edge.
  task automatic run_rect(input int x, input int y, input int ww, input int hh,
                          input logic [11:0] c, input bit disturb);
    int ew, eh, n, n0, t;
    ew = ww;
    eh = hh;
`ifdef FB_RECT_CLIP_EN
    ew = (x >= FB_W) ? 0 : ((ww < FB_W - x) ? ww : FB_W - x);
    eh = (y >= FB_H) ? 0 : ((hh < FB_H - y) ? hh : FB_H - y);
`endif
    for (int r = 0; r < eh; r++) begin
      for (int k = 0; k < ew; k++) begin
        exp_q.push_back({15'((x + k) + FB_W * (y + r)), c});
      end
    end
    n = ew * eh;
    wr_cnt = 0; first_wr = -1; last_wr = -1; done_cnt = 0; done_cyc = -1;
    x0 = 8'(x); y0 = 7'(y); w = 8'(ww); h = 7'(hh); color = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    n0 = cyc;
    start = 1'b0;
    chk("busy_setup", {31'd0, busy}, 32'd1);
    t = 0;
    while (done_cnt == 0 && t < n + 20) begin
      @(negedge clk);
      #1;
      t++;
      if (disturb && t == 2) begin
        start = 1'b1; x0 = 8'd40; y0 = 7'd40; w = 8'd7; h = 7'd7; color = 12'h0AB;
      end
      if (disturb && t == 3) start = 1'b0;
    end
    chk("done_seen", done_cnt, 1);
    chk("done_cycle", done_cyc, n0 + 1 + n);
    chk("write_count", wr_cnt, n);
    if (n > 0) begin
      chk("first_write_cycle", first_wr, n0 + 1);
      chk("last_write_cycle", last_wr, n0 + n);
    end
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    #1;
    chk("busy_low", {31'd0, busy}, 32'd0);
    chk("single_done", done_cnt, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wea", {31'd0, wea}, 32'd0);
    chk("rst_addra", {17'd0, addra}, 32'd0);
    chk("rst_dina", {20'd0, dina}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // First start on the very first rising edge after reset release.
    run_rect(10, 5, 3, 2, 12'hF00, 1'b0);
    run_rect(10, 5, 0, 4, 12'h00F, 1'b0);
    run_rect(10, 5, 4, 0, 12'h00F, 1'b0);
    run_rect(10, 5, 3, 2, 12'hF00, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    chk("no_queued_start", {31'd0, busy}, 32'd0);
    run_rect(150, 100, 10, 3, 12'h5A5, 1'b0);
    run_rect(0, 0, 1, 1, 12'h0FF, 1'b0);

    // Asynchronous reset in the middle of a fill.
    begin
      int t;
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 3; k++)
          exp_q.push_back({15'((10 + k) + FB_W * (5 + r)), 12'hF00});
      wr_cnt = 0; done_cnt = 0; first_wr = -1;
      x0 = 8'd10; y0 = 7'd5; w = 8'd3; h = 7'd2; color = 12'hF00;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      t = 0;
      while (wr_cnt < 3 && t < 20) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("mid_writes", wr_cnt, 3);
      #1 rst = 1'b0;
      #1;
      chk("arst_wea", {31'd0, wea}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      exp_q.delete();
      repeat (10) @(negedge clk);
      #1;
      chk("arst_no_done", done_cnt, 0);
      chk("arst_no_more_writes", wr_cnt, 3);
      chk("arst_addra", {17'd0, addra}, 32'd0);
      chk("arst_dina", {20'd0, dina}, 32'd0);
    end
    run_rect(20, 30, 4, 3, 12'h123, 1'b0);

`ifdef FB_RECT_CLIP_EN
    run_rect(158, 119, 5, 4, 12'hABC, 1'b0);
    run_rect(200, 10, 5, 5, 12'h321, 1'b0);
    run_rect(10, 125, 5, 5, 12'h321, 1'b0);
`endif

    run_rect(0, 0, 160, 120, 12'h777, 1'b0);
    chk("full_last_addr", {17'd0, addra}, 32'd19199);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
FB_RECT_WRITER -- requirements
Module: fb_rect_writer

Interface
REQ-001 Parameter FB_W, default 160, frame-buffer width in pixels.
REQ-002 Parameter FB_H, default 120, frame-buffer height in pixels.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to fill one rectangle; sampled only in IDLE.
REQ-006 x0  input  8  left column of the rectangle.
REQ-007 y0  input  7  top row of the rectangle.
REQ-008 w  input  8  width in pixels.
REQ-009 h  input  7  height in pixels.
REQ-010 color  input  12  RGB444 fill value.
REQ-011 busy  output  1  high in every non-IDLE state.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 wea  output  1  write enable to frame-buffer block RAM port.
REQ-014 addra  output  15  frame-buffer address, x + FB_W*y.
REQ-015 dina  output  12  write data; equals captured color.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, FILL, DONE.
REQ-017 IDLE: start=1 SHALL capture x0,y0,w,h,color and go to SETUP next cycle; start=0 stays IDLE.
REQ-018 SETUP (1 cycle): compute effective width ew, effective height eh and row-base address y0*FB_W; go to FILL if ew>0 and eh>0, else go to DONE.
REQ-019 FILL: one write per cycle, wea=1, raster order, left-to-right then top-to-bottom, starting at (x0,y0).
REQ-020 Row advance SHALL add FB_W to the row base; no multiplier in FILL.
REQ-021 After the write of pixel (x0+ew-1, y0+eh-1), go to DONE.
REQ-022 DONE (1 cycle): done=1, busy=1, wea=0; next state IDLE.
REQ-023 Latency: start sampled at edge N; first write at cycle N+2; last write at N+1+ew*eh; done at N+2+ew*eh; busy low again at N+3+ew*eh.
REQ-024 start while busy SHALL be ignored and not queued; input changes while busy SHALL have no effect.
REQ-025 wea SHALL be 0 outside FILL; addra and dina are don't-care when wea=0.
REQ-026 Maximum area 160x120 = 19200 writes; counters SHALL not overflow at that size.

Reset
REQ-027 rst=0 SHALL force IDLE immediately, without waiting for a clock edge.
REQ-028 Reset values: busy=0, done=0, wea=0, addra=0, dina=0, all counters 0.
REQ-029 Reset mid-FILL SHALL abort the fill with no further writes and no done pulse.
REQ-030 The first start SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-031 Macro FB_RECT_CLIP_EN selects clipping.
REQ-032 With FB_RECT_CLIP_EN defined:
- ew = 0 if x0>=FB_W, else min(w, FB_W-x0).
- eh = 0 if y0>=FB_H, else min(h, FB_H-y0).
- No write ever targets an address >= FB_W*FB_H.
REQ-033 Without FB_RECT_CLIP_EN: ew=w and eh=h; addresses SHALL be computed modulo 2^15, and in-range rectangles are the caller's responsibility.

Verification
REQ-034 x0=10,y0=5,w=3,h=2,color=0xF00 -> writes at 810,811,812,970,971,972 on cycles N+2..N+7, dina=0xF00, done at N+8.
REQ-035 w=0 or h=0 -> no wea, done at N+2, busy low at N+3.
REQ-036 Clip build: x0=158,y0=119,w=5,h=4 -> exactly 2 writes, at 19198 and 19199, then done.
REQ-037 Clip build: x0=200 -> zero writes, done at N+2; full frame 0,0,160,120 -> 19200 writes ending at 19199.
REQ-038 start pulsed during FILL with different params -> ignored; original 3x2 sequence unchanged, single done.
REQ-039 rst low for 1 ns mid-FILL -> wea and busy low asynchronously, no done; next start runs normally.
